serial_word_deserializer: RTL and testbench

Downstream consumer of the single-bit result stream produced by the package-task output-argument stage. Accepts one bit per handshake, assembles WIDTH bits LSB-first into a word, and presents the word with its even parity on a valid/ready output port. Parity is computed through a package task with an output argument, so the task-output-argument frontend path is exercised inside clocked logic.

---
 rtl/deser_pkg.sv | 18 +
 rtl/serial_word_deserializer.sv | 105 ++++++++++
 tb/tb_serial_word_deserializer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for serial_word_deserializer.
//   MAX_WIDTH   : widest word the parity helper accepts.
//   state_t     : COLLECT (accepting bits) / STALL (last slot blocked by a pending word).
//   calc_parity : even parity of a zero-extended word, returned via an output argument.
package deser_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    task automatic calc_parity(input logic [MAX_WIDTH-1:0] w, output logic p);
        p = ^w;
    endtask

endpackage

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler with parity.
// Collects WIDTH bits LSB-first over a valid/ready bit port and presents the
// finished word plus its XOR parity on a valid/ready word port.
// Ports:
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset
//   bit_i        : serial data bit
//   bit_valid_i  : bit_i valid this cycle
//   bit_ready_o  : bit_i accepted this cycle (combinational, allows same-cycle refill)
//   word_o       : assembled word, bit 0 received first
//   parity_o     : XOR of all bits of word_o
//   word_valid_o : word_o / parity_o valid
//   word_ready_i : consumer takes the word this cycle
module serial_word_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    output logic [WIDTH-1:0] word_o,
    output logic             parity_o,
    output logic             word_valid_o,
    input  logic             word_ready_i
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             parity_q, parity_d;
    logic             valid_q, valid_d;
    state_t           state_q, state_d;

    logic                 accept;
    logic                 complete;
    logic                 consume;
    logic [MAX_WIDTH-1:0] par_word;
    logic                 par_bit;

    // state_q is STALL exactly when the last slot is reached with a word still
    // pending, so only the current-cycle consumption needs to be checked here.
    assign bit_ready_o = !(state_q == STALL && !word_ready_i);

    always_comb begin
        accept   = bit_valid_i && bit_ready_o;
        complete = accept && (cnt_q == CntLast);
        consume  = valid_q && word_ready_i;

        sh_d     = sh_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        parity_d = parity_q;
        valid_d  = valid_q;
        par_word = '0;
        par_bit  = 1'b0;

        if (accept) begin
            sh_d[cnt_q] = bit_i;
            cnt_d       = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end

        // sh_d already holds the final bit in its top position on completion.
        par_word[WIDTH-1:0] = sh_d;
        calc_parity(par_word, par_bit);

        if (complete) begin
            word_d   = sh_d;
            parity_d = par_bit;
            valid_d  = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end

        state_d = (cnt_d == CntLast && valid_d) ? STALL : COLLECT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            parity_q <= 1'b0;
            valid_q  <= 1'b0;
            state_q  <= COLLECT;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            parity_q <= parity_d;
            valid_q  <= valid_d;
            state_q  <= state_d;
        end
    end

    assign word_o       = word_q;
    assign parity_o     = parity_q;
    assign word_valid_o = valid_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
module tb_serial_word_deserializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bit_i = 1'b0;
    logic         bit_valid_i = 1'b0;
    logic         bit_ready_o;
    logic [W-1:0] word_o;
    logic         parity_o;
    logic         word_valid_o;
    logic         word_ready_i = 1'b0;

    serial_word_deserializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .bit_ready_o  (bit_ready_o),
        .word_o       (word_o),
        .parity_o     (parity_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        logic         parity;
    } exp_t;

    exp_t exp_q[$];
    logic acc_bits[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted bits gather into a list; every W bits make one
    // expected word. The block stalls only on the last bit of a word while an
    // older word is still waiting and not being taken.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                acc_bits.delete();
            end else begin
                logic exp_ready;
                exp_ready = !(acc_bits.size() == W - 1 && exp_q.size() > 0 && !word_ready_i);
                check("bit_ready", 32'(bit_ready_o), 32'(exp_ready));
                check("word_valid", 32'(word_valid_o), 32'(exp_q.size() > 0));
                if (word_valid_o && exp_q.size() > 0) begin
                    check("word", 32'(word_o), 32'(exp_q[0].word));
                    check("parity", 32'(parity_o), 32'(exp_q[0].parity));
                    if (word_ready_i) void'(exp_q.pop_front());
                end
                if (bit_valid_i && bit_ready_o) begin
                    acc_bits.push_back(bit_i);
                    if (acc_bits.size() == W) begin
                        exp_t e;
                        e.word = '0;
                        for (int i = 0; i < W; i++) if (acc_bits[i]) e.word += (W'(1) << i);
                        e.parity = ($countones(e.word) % 2) == 1;
                        exp_q.push_back(e);
                        acc_bits.delete();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_wr) word_ready_i = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_bit(input logic b, input bit gaps);
        int waited;
        if (gaps) begin
            bit_valid_i = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                bit_i = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        bit_valid_i = 1'b1;
        bit_i = b;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bit_ready_o) break;
            waited++;
            if (waited > 500) begin
                check("send_timeout", 32'(waited), 32'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        bit_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit gaps);
        for (int i = 0; i < W; i++) send_bit(w[i], gaps);
    endtask

    task automatic check_idle_outputs(input string name);
        @(negedge clk);
        check({name, "_word"}, 32'(word_o), 32'(0));
        check({name, "_parity"}, 32'(parity_o), 32'(0));
        check({name, "_valid"}, 32'(word_valid_o), 32'(0));
        check({name, "_ready"}, 32'(bit_ready_o), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        word_ready_i = 1'b1;
        waited = 0;
        while (exp_q.size() > 0 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic [W-1:0] w2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle_outputs("reset");

        // Single word, always-ready consumer.
        word_ready_i = 1'b1;
        send_word(8'hA5, 1'b0);
        drain();

        // Back-to-back words, no bubble.
        send_word(8'h01, 1'b0);
        send_word(8'hFF, 1'b0);
        drain();

        // Consumer stalled: 7 more bits go in, the 8th blocks until the word is taken.
        word_ready_i = 1'b0;
        send_word(8'h3C, 1'b0);
        w2 = 8'h96;
        for (int i = 0; i < W - 1; i++) send_bit(w2[i], 1'b0);
        bit_valid_i = 1'b1;
        bit_i = w2[W-1];
        repeat (3) begin
            @(negedge clk);
            check("stall_ready", 32'(bit_ready_o), 32'(0));
            check("stall_hold", 32'(word_o), 32'(8'h3C));
        end
        @(posedge clk);
        #1;
        word_ready_i = 1'b1;
        @(negedge clk);
        check("refill_ready", 32'(bit_ready_o), 32'(1));
        @(posedge clk);
        #1;
        bit_valid_i = 1'b0;
        @(negedge clk);
        check("refill_valid", 32'(word_valid_o), 32'(1));
        check("refill_word", 32'(word_o), 32'(8'h96));
        @(posedge clk);
        #1;
        drain();

        // Reset in the middle of a word discards the partial bits.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle_outputs("midreset");
        send_word(8'hC3, 1'b0);
        drain();

        // Gapped input must match contiguous input.
        send_word(8'h5A, 1'b1);
        drain();

        // Random words, random gaps, random consumer back-pressure.
        rand_wr = 1'b1;
        for (int n = 0; n < 40; n++) send_word(W'($urandom), 1'b1);
        rand_wr = 1'b0;
        @(posedge clk);
        #1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL global_timeout: simulation did not finish, limit reached at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
